// File: rtl/sarray_mem_resp.sv
// Memory-side responder for the systolic array: serves ar/r loads and aw stores from a local
// word-addressed scratchpad through a fixed-latency read pipeline and a credit-gated response FIFO.

module sarray_mem_resp_chk #(
   parameter int DATA_WIDTH = 512,
   parameter int MAX_OUT    = 4,
   parameter int CW         = 3
) (
   input logic                  clk,
   input logic                  rst,
   input logic [CW-1:0]         cnt,
   input logic                  fifo_full,
   input logic                  fifo_push,
   input logic                  r_valid,
   input logic                  r_ready,
   input logic [DATA_WIDTH-1:0] r_data
);
   a_cnt_bound: assert property (@(posedge clk) disable iff (rst) cnt <= CW'(MAX_OUT));
   a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(fifo_push && fifo_full));
   a_r_stable: assert property (@(posedge clk) disable iff (rst)
      (r_valid && !r_ready) |=> (r_valid && $stable(r_data)));
endmodule

module sarray_mem_resp #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 512,
   parameter int DEPTH      = 256,
   parameter int RD_LAT     = 2,
   parameter int MAX_OUT    = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sarray_ar_valid_i,
   output logic                  sarray_ar_ready_o,
   input  logic [ADDR_WIDTH-1:0] sarray_ar_addr_i,
   output logic                  sarray_r_valid_o,
   input  logic                  sarray_r_ready_i,
   output logic [DATA_WIDTH-1:0] sarray_r_data_o,
   input  logic                  sarray_aw_valid_i,
   output logic                  sarray_aw_ready_o,
   input  logic [ADDR_WIDTH-1:0] sarray_aw_addr_i,
   input  logic [DATA_WIDTH-1:0] sarray_aw_data_i,
   output logic                  addr_err_o
);
   localparam int OFF = $clog2(DATA_WIDTH / 8);
   localparam int IDX = $clog2(DEPTH);
   localparam int CW  = $clog2(MAX_OUT + 1);
   localparam int PW  = $clog2(MAX_OUT);

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];
   logic [DATA_WIDTH-1:0] fifo_mem_r [MAX_OUT];
   logic                  rst_q_r;
   logic [CW-1:0]         cnt_r;
   logic [CW-1:0]         cnt_nxt_s;
   logic [PW:0]           wr_ptr_r;
   logic [PW:0]           rd_ptr_r;
   logic                  addr_err_r;
   logic                  ar_hs_s;
   logic                  aw_hs_s;
   logic                  r_hs_s;
   logic [IDX-1:0]        ar_idx_s;
   logic [IDX-1:0]        aw_idx_s;
   logic                  ar_oor_s;
   logic                  aw_oor_s;
   logic [DATA_WIDTH-1:0] rd_data_s;
   logic                  push_s;
   logic [DATA_WIDTH-1:0] push_data_s;
   logic                  fifo_empty_s;
   logic                  fifo_full_s;
   logic                  unused_s;

   assign ar_idx_s = sarray_ar_addr_i[OFF+IDX-1:OFF];
   assign aw_idx_s = sarray_aw_addr_i[OFF+IDX-1:OFF];
   assign ar_oor_s = |sarray_ar_addr_i[ADDR_WIDTH-1:OFF+IDX];
   assign aw_oor_s = |sarray_aw_addr_i[ADDR_WIDTH-1:OFF+IDX];
   assign unused_s = ^{sarray_ar_addr_i[OFF-1:0], sarray_aw_addr_i[OFF-1:0]};

   assign sarray_ar_ready_o = !rst_q_r && (cnt_r < CW'(MAX_OUT));
   assign sarray_aw_ready_o = !rst_q_r;
   assign ar_hs_s = sarray_ar_valid_i && sarray_ar_ready_o;
   assign aw_hs_s = sarray_aw_valid_i && sarray_aw_ready_o;
   assign r_hs_s  = sarray_r_valid_o && sarray_r_ready_i;

   // Out-of-range reads yield a zero beat; the array is read with pre-write contents.
   assign rd_data_s = ar_oor_s ? {DATA_WIDTH{1'b0}} : mem_r[ar_idx_s];

   assign fifo_empty_s = (wr_ptr_r == rd_ptr_r);
   assign fifo_full_s  = (wr_ptr_r[PW] != rd_ptr_r[PW]) && (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]);
   assign sarray_r_valid_o = !fifo_empty_s;
   assign sarray_r_data_o  = fifo_mem_r[rd_ptr_r[PW-1:0]] & {DATA_WIDTH{sarray_r_valid_o}};
   assign addr_err_o       = addr_err_r;

   // Scratchpad write port; contents intentionally survive reset.
   always_ff @(posedge clk) begin
      if (aw_hs_s && !aw_oor_s) begin
         mem_r[aw_idx_s] <= sarray_aw_data_i;
      end
   end

   generate
      if (RD_LAT == 1) begin : g_lat1
         assign push_s      = ar_hs_s;
         assign push_data_s = rd_data_s;
      end else begin : g_latn
         logic [RD_LAT-2:0]     stg_vld_r;
         logic [DATA_WIDTH-1:0] stg_data_r [RD_LAT-1];

         // Read pipeline: stage 0 captures on the ar handshake, later stages shift.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               stg_vld_r <= '0;
               for (int i = 0; i < RD_LAT - 1; i++) begin
                  stg_data_r[i] <= '0;
               end
            end else begin
               stg_vld_r[0]  <= ar_hs_s;
               stg_data_r[0] <= rd_data_s;
               for (int i = 1; i < RD_LAT - 1; i++) begin
                  stg_vld_r[i]  <= stg_vld_r[i-1];
                  stg_data_r[i] <= stg_data_r[i-1];
               end
            end
         end

         assign push_s      = stg_vld_r[RD_LAT-2];
         assign push_data_s = stg_data_r[RD_LAT-2];
      end
   endgenerate

   // Response FIFO storage; pointers alone decide validity.
   always_ff @(posedge clk) begin
      if (push_s) begin
         fifo_mem_r[wr_ptr_r[PW-1:0]] <= push_data_s;
      end
   end

   // Credit update: accepted reads take a credit, delivered responses return one.
   always_comb begin
      cnt_nxt_s = cnt_r;
      case ({ar_hs_s, r_hs_s})
         2'b10:   cnt_nxt_s = cnt_r + CW'(1);
         2'b01:   cnt_nxt_s = cnt_r - CW'(1);
         default: cnt_nxt_s = cnt_r;
      endcase
   end

   // Control state: registered reset, credits, FIFO pointers and sticky address error.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rst_q_r    <= 1'b1;
         cnt_r      <= '0;
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         addr_err_r <= 1'b0;
      end else begin
         rst_q_r    <= 1'b0;
         cnt_r      <= cnt_nxt_s;
         wr_ptr_r   <= wr_ptr_r + (PW+1)'(push_s);
         rd_ptr_r   <= rd_ptr_r + (PW+1)'(r_hs_s);
         addr_err_r <= addr_err_r | (ar_hs_s && ar_oor_s) | (aw_hs_s && aw_oor_s);
      end
   end

   sarray_mem_resp_chk #(
      .DATA_WIDTH(DATA_WIDTH),
      .MAX_OUT   (MAX_OUT),
      .CW        (CW)
   ) u_chk (
      .clk      (clk),
      .rst      (rst),
      .cnt      (cnt_r),
      .fifo_full(fifo_full_s),
      .fifo_push(push_s),
      .r_valid  (sarray_r_valid_o),
      .r_ready  (sarray_r_ready_i),
      .r_data   (sarray_r_data_o)
   );
endmodule

// File: tb/tb_sarray_mem_resp.sv
// Bench for sarray_mem_resp: table of store/load vectors plus hand-written latency, backpressure,
// read-before-write, out-of-range and reset sequences; load data checked through an ordered scoreboard.

module tb_sarray_mem_resp;
   localparam int AW = 32;
   localparam int DW = 512;

   logic          clk = 1'b0;
   logic          rst;
   logic          ar_valid;
   logic          ar_ready;
   logic [AW-1:0] ar_addr;
   logic          r_valid;
   logic          r_ready;
   logic [DW-1:0] r_data;
   logic          aw_valid;
   logic          aw_ready;
   logic [AW-1:0] aw_addr;
   logic [DW-1:0] aw_data;
   logic          addr_err;

   int n_cmp = 0;
   int n_bad = 0;
   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] mdl [int];

   typedef struct {
      bit            is_wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } vec_t;
   vec_t tbl [8];

   sarray_mem_resp dut (
      .clk              (clk),
      .rst              (rst),
      .sarray_ar_valid_i(ar_valid),
      .sarray_ar_ready_o(ar_ready),
      .sarray_ar_addr_i (ar_addr),
      .sarray_r_valid_o (r_valid),
      .sarray_r_ready_i (r_ready),
      .sarray_r_data_o  (r_data),
      .sarray_aw_valid_i(aw_valid),
      .sarray_aw_ready_o(aw_ready),
      .sarray_aw_addr_i (aw_addr),
      .sarray_aw_data_i (aw_data),
      .addr_err_o       (addr_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Response monitor: pops the scoreboard on every r handshake and checks stall stability.
   logic [DW-1:0] held_d;
   bit            held_v = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         held_v = 1'b0;
      end else begin
         if (held_v && r_valid) check("r_stable", r_data, held_d);
         if (r_valid && r_ready) begin
            if (exp_q.size() == 0) check("r_unexpected", DW'(r_valid), DW'(0));
            else check("r_data", r_data, exp_q.pop_front());
         end
         held_v = r_valid && !r_ready;
         held_d = r_data;
      end
   end

   task automatic ar_issue(input logic [AW-1:0] a, input logic [DW-1:0] e, input int budget,
                           output bit acc);
      acc = 1'b0;
      ar_valid = 1'b1;
      ar_addr = a;
      for (int i = 0; i < budget && !acc; i++) begin
         @(negedge clk);
         if (ar_ready) begin
            exp_q.push_back(e);
            acc = 1'b1;
         end
         @(posedge clk); #1;
      end
      ar_valid = 1'b0;
   endtask

   task automatic aw_issue(input logic [AW-1:0] a, input logic [DW-1:0] d);
      aw_valid = 1'b1;
      aw_addr = a;
      aw_data = d;
      @(negedge clk);
      check("aw_ready", DW'(aw_ready), DW'(1));
      if (a[AW-1:14] == '0) mdl[int'(a[13:6])] = d;
      @(posedge clk); #1;
      aw_valid = 1'b0;
   endtask

   function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
      if (a[AW-1:14] != '0) return '0;
      return mdl[int'(a[13:6])];
   endfunction

   task automatic wait_drain(input int budget);
      for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
         @(posedge clk); #1;
      end
      if (exp_q.size() != 0) check("drain_timeout", DW'(exp_q.size()), DW'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      bit acc;
      int n_acc;

      rst = 1'b1; ar_valid = 1'b0; aw_valid = 1'b0; r_ready = 1'b1;
      ar_addr = '0; aw_addr = '0; aw_data = '0;

      // Reset: ports quiet even with valids pulsed
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         ar_valid = (i == 1); aw_valid = (i == 1);
         @(negedge clk);
         check("rst_ar_ready", DW'(ar_ready), DW'(0));
         check("rst_aw_ready", DW'(aw_ready), DW'(0));
         check("rst_r_valid", DW'(r_valid), DW'(0));
         check("rst_addr_err", DW'(addr_err), DW'(0));
      end
      @(posedge clk); #1;
      rst = 1'b0; ar_valid = 1'b0; aw_valid = 1'b0;
      @(negedge clk);
      check("rel_ar_ready_c0", DW'(ar_ready), DW'(0));
      @(posedge clk); #1;
      @(negedge clk);
      check("rel_ar_ready_c1", DW'(ar_ready), DW'(1));
      check("rel_aw_ready_c1", DW'(aw_ready), DW'(1));
      @(posedge clk); #1;

      // Table of stores followed by aliased and boundary-word loads
      tbl[0] = '{1'b1, 32'h0000_0040, {64{8'hA5}}};
      tbl[1] = '{1'b1, 32'h0000_0080, {64{8'h11}}};
      tbl[2] = '{1'b1, 32'h0000_0000, {64{8'hC3}}};
      tbl[3] = '{1'b1, 32'h0000_3FC0, {64{8'h77}}};
      tbl[4] = '{1'b0, 32'h0000_007F, {64{8'hA5}}};
      tbl[5] = '{1'b0, 32'h0000_3FFF, {64{8'h77}}};
      tbl[6] = '{1'b0, 32'h0000_0000, {64{8'hC3}}};
      tbl[7] = '{1'b0, 32'h0000_0080, {64{8'h11}}};
      for (int i = 0; i < 8; i++) begin
         if (tbl[i].is_wr) aw_issue(tbl[i].addr, tbl[i].data);
         else begin
            ar_issue(tbl[i].addr, tbl[i].data, 4, acc);
            check("tbl_ar_acc", DW'(acc), DW'(1));
         end
      end
      wait_drain(20);

      // Latency: handshake in T, r_valid first in T+2
      ar_issue(32'h0000_0040, {64{8'hA5}}, 4, acc);
      @(negedge clk);
      check("lat_t1_r_valid", DW'(r_valid), DW'(0));
      @(posedge clk); #1;
      @(negedge clk);
      check("lat_t2_r_valid", DW'(r_valid), DW'(1));
      @(posedge clk); #1;
      wait_drain(10);

      // Backpressure: only MAX_OUT reads accepted, then drained in order
      for (int i = 0; i < 4; i++) aw_issue(32'h100 + 32'(i * 64), {64{8'hB0 + 8'(i)}});
      r_ready = 1'b0;
      n_acc = 0;
      for (int i = 0; i < 6; i++) begin
         ar_issue(32'h100 + 32'((i % 4) * 64), model_rd(32'h100 + 32'((i % 4) * 64)), 3, acc);
         n_acc += int'(acc);
      end
      check("bp_accepted", DW'(n_acc), DW'(4));
      @(negedge clk);
      check("bp_ar_ready", DW'(ar_ready), DW'(0));
      check("bp_r_valid", DW'(r_valid), DW'(1));
      @(posedge clk); #1;
      r_ready = 1'b1;
      wait_drain(20);

      // Same-cycle ar+aw: old data, then new data
      ar_valid = 1'b1; ar_addr = 32'h80;
      aw_valid = 1'b1; aw_addr = 32'h80; aw_data = {64{8'h22}};
      @(negedge clk);
      check("rbw_ar_ready", DW'(ar_ready), DW'(1));
      exp_q.push_back({64{8'h11}});
      mdl[2] = {64{8'h22}};
      @(posedge clk); #1;
      ar_valid = 1'b0; aw_valid = 1'b0;
      ar_issue(32'h80, {64{8'h22}}, 4, acc);
      wait_drain(20);

      // Out of range: zero beat, sticky error, store dropped
      @(negedge clk);
      check("oor_err_before", DW'(addr_err), DW'(0));
      @(posedge clk); #1;
      ar_issue(32'h0001_0000, '0, 4, acc);
      wait_drain(20);
      @(negedge clk);
      check("oor_err_after", DW'(addr_err), DW'(1));
      @(posedge clk); #1;
      aw_issue(32'h0001_0000, {64{8'hEE}});
      ar_issue(32'h0, {64{8'hC3}}, 4, acc);
      ar_issue(32'h40, {64{8'hA5}}, 4, acc);
      wait_drain(20);
      @(negedge clk);
      check("oor_err_sticky", DW'(addr_err), DW'(1));
      @(posedge clk); #1;

      // Reset with reads in flight: nothing emerges, full credits return
      r_ready = 1'b0;
      for (int i = 0; i < 3; i++) ar_issue(32'h40, {64{8'hA5}}, 4, acc);
      rst = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      r_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("post_rst_r_valid", DW'(r_valid), DW'(0));
         @(posedge clk); #1;
      end
      @(negedge clk);
      check("post_rst_addr_err", DW'(addr_err), DW'(0));
      @(posedge clk); #1;
      r_ready = 1'b0;
      n_acc = 0;
      for (int i = 0; i < 5; i++) begin
         ar_issue(32'h100 + 32'((i % 4) * 64), model_rd(32'h100 + 32'((i % 4) * 64)), 3, acc);
         n_acc += int'(acc);
      end
      check("post_rst_credits", DW'(n_acc), DW'(4));
      r_ready = 1'b1;
      wait_drain(20);
      repeat (3) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
